// File: rtl/wb_bram_pkg.sv
// rtl/wb_bram_pkg.sv - shared state encoding and constants for wb_bram_ctrl
//
// Purpose: FSM state type, BRAM read latency and the default Wishbone
//          window used by wb_bram_ctrl and its testbench.
// Ports:   none (package).
package wb_bram_pkg;

  // Cycles from the EN0 edge to valid Do0 on the user-project BRAM.
  localparam int unsigned BRAM_RD_LAT = 1;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h3800_0000;
  localparam logic [31:0] DEFAULT_ADDR_MASK = 32'hFFC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd2,
    WAIT  = 3'd3,
    ACK   = 3'd4
  } state_e;

endpackage

// File: rtl/wb_wait_cnt.sv
// rtl/wb_wait_cnt.sv - 8-bit loadable down-counter that times the ACK wait states
//
// Purpose: load a wait count, decrement it on request, flag the last wait cycle.
// Ports:   clk, rst_n (async, active-low)
//          load, load_val[7:0] - load a new count (wins over dec)
//          dec                 - decrement by one, saturating at 0
//          done                - high while the count equals 1 (last wait cycle)
module wb_wait_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done on 1, not 0: the FSM moves to ACK on the edge that closes this cycle.
  assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/wb_bram_ctrl.sv
// rtl/wb_bram_ctrl.sv - Wishbone classic slave driving the single port of a byte-write BRAM
//
// Purpose: turn each Wishbone access inside the address window into one BRAM
//          EN0 pulse, capture Do0 the cycle after, and ACK after DELAYS waits.
// Ports:   CLK, RST_N (async, active-low)
//          wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i[3:0], wb_adr_i[31:0], wb_dat_i[31:0]
//          wb_dat_o[31:0] (registered read data), wb_ack_o (registered, 1 cycle)
//          bram_EN0, bram_WE0[3:0], bram_A0[31:0], bram_Di0[31:0] (all registered)
//          bram_Do0[31:0] (BRAM read data, valid the cycle after EN0)
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK = DEFAULT_ADDR_MASK,
  parameter int unsigned N         = 12,
  parameter int unsigned DELAYS    = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        bram_EN0,
  output logic [3:0]  bram_WE0,
  output logic [31:0] bram_A0,
  output logic [31:0] bram_Di0,
  input  logic [31:0] bram_Do0
);

  localparam logic [7:0] DELAY_LOAD = 8'(DELAYS);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [N-1:0] a0_q, a0_d;
  logic [31:0] di0_q, di0_d;
  logic [31:0] dat_q, dat_d;
  logic        en0_q, en0_d;
  logic [3:0]  we0_q, we0_d;
  logic        ack_q, ack_d;

  logic        req_hit;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_done;

  assign req_hit = wb_cyc_i && wb_stb_i && ((wb_adr_i & ADDR_MASK) == ADDR_BASE);

  wb_wait_cnt u_wait_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (DELAY_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Outputs are one cycle ahead in *_d: the value computed here is what the
  // bus/BRAM sees during the next state, so nothing on wb_* reaches an output
  // without passing a flop.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    a0_d     = a0_q;
    di0_d    = di0_q;
    dat_d    = dat_q;
    en0_d    = 1'b0;
    we0_d    = 4'b0000;
    ack_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_hit) begin
          we_d    = wb_we_i;
          a0_d    = wb_adr_i[N+1:2];
          di0_d   = wb_dat_i;
          en0_d   = 1'b1;
          we0_d   = wb_we_i ? wb_sel_i : 4'b0000;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The EN0 pulse already on the bus completes even when aborting.
        state_d = wb_cyc_i ? CAPT : IDLE;
      end
      CAPT: begin
        dat_d = we_q ? 32'h0 : bram_Do0;
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (DELAY_LOAD == 8'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      a0_q    <= '0;
      di0_q   <= 32'h0;
      dat_q   <= 32'h0;
      en0_q   <= 1'b0;
      we0_q   <= 4'b0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      a0_q    <= a0_d;
      di0_q   <= di0_d;
      dat_q   <= dat_d;
      en0_q   <= en0_d;
      we0_q   <= we0_d;
      ack_q   <= ack_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign bram_EN0 = en0_q;
  assign bram_WE0 = we0_q;
  assign bram_A0  = {{(32-N){1'b0}}, a0_q};
  assign bram_Di0 = di0_q;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb/tb_wb_bram_ctrl.sv - scoreboard bench for wb_bram_ctrl (instance 0: DELAYS=10, instance 1: DELAYS=0)
module tb_wb_bram_ctrl;

  localparam int N     = 12;
  localparam int WORDS = 4096;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] di0;
  } en_exp_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] dat;
  } ack_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        wb_cyc   [2];
  logic        wb_stb   [2];
  logic        wb_we    [2];
  logic [3:0]  wb_sel   [2];
  logic [31:0] wb_adr   [2];
  logic [31:0] wb_dat_i [2];
  logic [31:0] wb_dat_o [2];
  logic        wb_ack   [2];
  logic        bram_en  [2];
  logic [3:0]  bram_we  [2];
  logic [31:0] bram_a   [2];
  logic [31:0] bram_di  [2];

  logic [31:0] ref_mem [2][WORDS];
  en_exp_t     en_q[$];
  ack_exp_t    ack_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_seen [2];
  int          ack_seen[2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [WORDS];
    logic [31:0] do_r;

    initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
    end

    // Behavioural BRAM: read-first, byte writes, Do0 is 0 the cycle after an idle cycle.
    always @(posedge clk) begin
      if (bram_en[g]) begin
        do_r <= mem[bram_a[g][N-1:0]];
        for (int b = 0; b < 4; b++) begin
          if (bram_we[g][b]) mem[bram_a[g][N-1:0]][8*b +: 8] = bram_di[g][8*b +: 8];
        end
      end else begin
        do_r <= 32'h0;
      end
    end

    wb_bram_ctrl #(
      .N      (N),
      .DELAYS (g == 0 ? 10 : 0)
    ) u_dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .wb_cyc_i (wb_cyc[g]),
      .wb_stb_i (wb_stb[g]),
      .wb_we_i  (wb_we[g]),
      .wb_sel_i (wb_sel[g]),
      .wb_adr_i (wb_adr[g]),
      .wb_dat_i (wb_dat_i[g]),
      .wb_dat_o (wb_dat_o[g]),
      .wb_ack_o (wb_ack[g]),
      .bram_EN0 (bram_en[g]),
      .bram_WE0 (bram_we[g]),
      .bram_A0  (bram_a[g]),
      .bram_Di0 (bram_di[g]),
      .bram_Do0 (do_r)
    );
  end

  function automatic int dly(input int g);
    return (g == 0) ? 10 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: every EN0 pulse and every ACK must match the head of its queue.
  always @(negedge clk) begin
    en_exp_t  e;
    ack_exp_t a;
    if (rst_n) begin
      for (int g = 0; g < 2; g++) begin
        if (bram_en[g]) begin
          en_seen[g]++;
          if (en_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL en0_unexpected: inst %0d pulse at cycle %0d, required none", g, cyc_cnt);
          end else begin
            e = en_q.pop_front();
            chk("en0_inst", g, e.inst);
            chk("en0_cycle", cyc_cnt, e.cyc);
            chk("en0_a0", bram_a[g], e.a0);
            chk("en0_we0", {28'h0, bram_we[g]}, {28'h0, e.we0});
            chk("en0_di0", bram_di[g], e.di0);
          end
        end else begin
          chk("we0_without_en0", {28'h0, bram_we[g]}, 32'h0);
        end
        if (wb_ack[g]) begin
          ack_seen[g]++;
          if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: inst %0d ack at cycle %0d, required none", g, cyc_cnt);
          end else begin
            a = ack_q.pop_front();
            chk("ack_inst", g, a.inst);
            chk("ack_cycle", cyc_cnt, a.cyc);
            chk("ack_data", wb_dat_o[g], a.dat);
          end
        end
      end
    end
  end

  // Caller is #1 after a rising edge; this cycle becomes cycle 0 of the access.
  task automatic start_access(input int g, input logic we, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] dat,
                              input logic expect_it, input logic use_exp,
                              input logic [31:0] exp_rd);
    int          t0;
    logic [31:0] idx;
    logic [31:0] rd;
    t0 = cyc_cnt;
    wb_cyc[g]   = 1'b1;
    wb_stb[g]   = 1'b1;
    wb_we[g]    = we;
    wb_sel[g]   = sel;
    wb_adr[g]   = adr;
    wb_dat_i[g] = dat;
    if (expect_it) begin
      idx = (adr >> 2) % WORDS;
      en_q.push_back('{inst: g, cyc: t0 + 1, a0: idx, we0: (we ? sel : 4'h0), di0: dat});
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) ref_mem[g][idx][8*b +: 8] = dat[8*b +: 8];
        end
        rd = 32'h0;
      end else begin
        rd = use_exp ? exp_rd : ref_mem[g][idx];
      end
      ack_q.push_back('{inst: g, cyc: t0 + 3 + dly(g), dat: rd});
    end
  endtask

  // Scrambles the request after cycle 0 (must be ignored), waits for ACK, releases the bus.
  task automatic finish_access(input int g);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    wb_adr[g]   = $urandom;
    wb_dat_i[g] = $urandom;
    wb_sel[g]   = 4'($urandom);
    wb_we[g]    = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_ack[g]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: inst %0d no ack within 40 cycles", g);
    end
    @(posedge clk);
    #1;
    wb_cyc[g] = 1'b0;
    wb_stb[g] = 1'b0;
  endtask

  task automatic access(input int g, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic use_exp, input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    start_access(g, we, sel, adr, dat, 1'b1, use_exp, exp_rd);
    finish_access(g);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    int          en_base;
    int          ack_base;
    logic [31:0] adr;
    logic [31:0] word;
    int          g;

    for (int i = 0; i < 2; i++) begin
      wb_cyc[i] = 1'b0; wb_stb[i] = 1'b0; wb_we[i] = 1'b0; wb_sel[i] = 4'h0;
      wb_adr[i] = 32'h0; wb_dat_i[i] = 32'h0;
      en_seen[i] = 0; ack_seen[i] = 0;
      for (int j = 0; j < WORDS; j++) ref_mem[i][j] = 32'h0;
    end

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_dat_o", wb_dat_o[i], 32'h0);
      chk("rst_ack", {31'h0, wb_ack[i]}, 32'h0);
      chk("rst_en0", {31'h0, bram_en[i]}, 32'h0);
      chk("rst_we0", {28'h0, bram_we[i]}, 32'h0);
      chk("rst_a0", bram_a[i], 32'h0);
      chk("rst_di0", bram_di[i], 32'h0);
    end
    rst_n = 1'b1;

    // Full write then read-back, then a single-lane merge.
    access(0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access(0, 1'b0, 4'hF, 32'h3800_0010, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF);
    access(0, 1'b1, 4'b0010, 32'h3800_0010, 32'h0000_AB00, 1'b0, 32'h0);
    access(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 1'b1, 32'hDEAD_ABEF);

    // Zero-wait instance: write, sel=0 write (no bytes change), read, back-to-back reads.
    access(1, 1'b1, 4'hF, 32'h3800_0040, 32'hCAFE_F00D, 1'b0, 32'h0);
    access(1, 1'b1, 4'h0, 32'h3800_0040, 32'h1111_1111, 1'b0, 32'h0);
    access(1, 1'b0, 4'hF, 32'h3800_0040, 32'h0, 1'b1, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    t0 = cyc_cnt;
    wb_cyc[1] = 1'b1; wb_stb[1] = 1'b1; wb_we[1] = 1'b0; wb_sel[1] = 4'hF;
    wb_adr[1] = 32'h3800_0040; wb_dat_i[1] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      en_q.push_back('{inst: 1, cyc: t0 + 1 + 4*k, a0: 32'h10, we0: 4'h0, di0: 32'h0});
      ack_q.push_back('{inst: 1, cyc: t0 + 3 + 4*k, dat: 32'hCAFE_F00D});
    end
    repeat (8) @(posedge clk);
    #1;
    wb_cyc[1] = 1'b0; wb_stb[1] = 1'b0;

    // Miss held for 20 cycles.
    en_base  = en_seen[0];
    ack_base = ack_seen[0];
    @(posedge clk);
    #1;
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b0; wb_adr[0] = 32'h3900_0000;
    repeat (20) @(posedge clk);
    #1;
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    repeat (2) @(posedge clk);
    chk("miss_en0_count", en_seen[0] - en_base, 32'h0);
    chk("miss_ack_count", ack_seen[0] - ack_base, 32'h0);

    // Abort in WAIT at cycle 5; a read started at cycle 6 must issue at cycle 7.
    ack_base = ack_seen[0];
    @(posedge clk);
    #1;
    start_access(0, 1'b1, 4'hF, 32'h3800_0100, 32'h5A5A_0F0F, 1'b1, 1'b0, 32'h0);
    void'(ack_q.pop_back());
    repeat (5) @(posedge clk);
    #1;
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    @(posedge clk);
    #1;
    start_access(0, 1'b0, 4'hF, 32'h3800_0100, 32'h0, 1'b1, 1'b1, 32'h5A5A_0F0F);
    finish_access(0);
    chk("abort_ack_count", ack_seen[0] - ack_base, 32'h1);

    // Reset during ISSUE of a write: outputs drop at once, old word survives.
    access(0, 1'b1, 4'hF, 32'h3800_0200, 32'h0BAD_F00D, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    start_access(0, 1'b1, 4'hF, 32'h3800_0200, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_rst_en0", {31'h0, bram_en[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en0", {31'h0, bram_en[0]}, 32'h0);
    chk("rst_mid_we0", {28'h0, bram_we[0]}, 32'h0);
    chk("rst_mid_ack", {31'h0, wb_ack[0]}, 32'h0);
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    access(0, 1'b0, 4'hF, 32'h3800_0200, 32'h0, 1'b1, 32'h0BAD_F00D);

    // Random traffic with aliased upper address bits and the top word index.
    for (int it = 0; it < 30; it++) begin
      g    = int'($urandom_range(0, 1));
      word = ($urandom_range(0, 3) == 0) ? 32'(WORDS - 1) : 32'($urandom_range(0, 15));
      adr  = 32'h3800_0000 | (32'($urandom_range(0, 255)) << 14) | (word << 2)
           | 32'($urandom_range(0, 3));
      access(g, 1'($urandom), 4'($urandom), adr, $urandom, 1'b0, 32'h0);
    end

    repeat (5) @(posedge clk);
    chk("en0_pending", en_q.size(), 32'h0);
    chk("ack_pending", ack_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
